// File: rtl/pipelined_alu_pkg.sv
// pipelined_alu_pkg: shared mode encodings and saturation limit for the pipelined ALU
package pipelined_alu_pkg;

    typedef enum logic [1:0] {
        MODE_SUM   = 2'b00,
        MODE_RANGE = 2'b01,
        MODE_MAC   = 2'b10,
        MODE_ACC   = 2'b11
    } mode_e;

    function automatic logic [63:0] sat_limit(input int ow);
        return (ow >= 64) ? '1 : (64'd1 << ow) - 64'd1;
    endfunction

endpackage

// File: rtl/pipelined_alu_reduce.sv
// alu_reduce: combinational sum, max and min over N unsigned W-bit operands
module alu_reduce #(
    parameter int W = 5,
    parameter int N = 5
) (
    input  logic [N*W-1:0] ops_i,
    output logic [W+2:0]   sum_o,
    output logic [W-1:0]   max_o,
    output logic [W-1:0]   min_o
);

    always_comb begin
        sum_o = '0;
        max_o = '0;
        min_o = '1;
        for (int i = 0; i < N; i++) begin
            sum_o = sum_o + (W+3)'(ops_i[i*W +: W]);
            max_o = (ops_i[i*W +: W] > max_o) ? ops_i[i*W +: W] : max_o;
            min_o = (ops_i[i*W +: W] < min_o) ? ops_i[i*W +: W] : min_o;
        end
    end

endmodule

// File: rtl/pipelined_alu.sv
// pipelined_alu: 3-stage SUM/RANGE/MAC/ACC unit with saturating results and accumulator
module pipelined_alu
    import pipelined_alu_pkg::*;
#(
    parameter int W  = 5,
    parameter int N  = 5,
    parameter int OW = 2*W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [1:0]     mode,
    input  logic [N*W-1:0] in_number,
    input  logic           acc_clr,
    output logic           out_valid,
    output logic [OW-1:0]  out_number
);

    localparam int SW = W + 3;
    localparam int RW = (2*W + 1 > SW) ? 2*W + 1 : SW;

    if (OW < W + 3) begin : g_ow_chk
        $error("pipelined_alu: OW must be >= W+3");
    end
    if (N < 2 || N > 8) begin : g_n_chk
        $error("pipelined_alu: N must be in 2..8");
    end

    logic           s1_valid_q, s1_clr_q;
    mode_e          s1_mode_q;
    logic [N*W-1:0] s1_ops_q;

    logic           s2_valid_q, s2_clr_q;
    mode_e          s2_mode_q;
    logic [RW-1:0]  s2_res_q, s2_res_d;
    logic [SW-1:0]  s2_sum_q;

    logic           out_valid_q;
    logic [OW-1:0]  out_number_q, out_number_d;
    logic [OW-1:0]  acc_q, acc_d;

    logic [SW-1:0]  red_sum;
    logic [W-1:0]   red_max, red_min, op2;
    logic [OW:0]    acc_sum;
    logic [OW-1:0]  acc_sat, res_sat;

    alu_reduce #(.W(W), .N(N)) u_reduce (
        .ops_i (s1_ops_q),
        .sum_o (red_sum),
        .max_o (red_max),
        .min_o (red_min)
    );

    // op2 is absent when N == 2; a loop select avoids an out-of-range slice
    always_comb begin
        op2 = '0;
        for (int i = 0; i < N; i++)
            if (i == 2) op2 = s1_ops_q[i*W +: W];
    end

    always_comb begin
        s2_res_d = (s1_mode_q == MODE_RANGE) ? RW'(red_max) - RW'(red_min) :
                   (s1_mode_q == MODE_MAC)   ? RW'(s1_ops_q[0 +: W]) * RW'(s1_ops_q[W +: W]) + RW'(op2) :
                                               RW'(red_sum);
    end

    always_comb begin
        acc_sum      = (s2_clr_q ? (OW+1)'(0) : (OW+1)'(acc_q)) + (OW+1)'(s2_sum_q);
        acc_sat      = (64'(acc_sum) > sat_limit(OW)) ? OW'(sat_limit(OW)) : acc_sum[OW-1:0];
        res_sat      = (64'(s2_res_q) > sat_limit(OW)) ? OW'(sat_limit(OW)) : OW'(s2_res_q);
        acc_d        = !s2_valid_q             ? acc_q :
                       (s2_mode_q == MODE_ACC) ? acc_sat :
                       s2_clr_q                ? '0 : acc_q;
        out_number_d = !s2_valid_q             ? '0 :
                       (s2_mode_q == MODE_ACC) ? acc_sat : res_sat;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_number_q <= '0;
            acc_q        <= '0;
        end else begin
            s1_valid_q   <= in_valid;
            s1_clr_q     <= in_valid & acc_clr;
            s1_mode_q    <= mode_e'(mode);
            s1_ops_q     <= in_number;
            s2_valid_q   <= s1_valid_q;
            s2_clr_q     <= s1_clr_q;
            s2_mode_q    <= s1_mode_q;
            s2_res_q     <= s2_res_d;
            s2_sum_q     <= red_sum;
            out_valid_q  <= s2_valid_q;
            out_number_q <= out_number_d;
            acc_q        <= acc_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_number = out_number_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// tb_pipelined_alu: directed vectors with a queued scoreboard checked by a cycle-aware monitor
module tb_pipelined_alu;

    localparam int W = 5, N = 5, OW = 10;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n, in_valid, acc_clr;
    logic [1:0]     mode;
    logic [N*W-1:0] in_number;
    logic           out_valid;
    logic [OW-1:0]  out_number;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   started = 0;
    exp_t q[$];

    pipelined_alu #(.W(W), .N(N), .OW(OW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .mode       (mode),
        .in_number  (in_number),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid),
        .out_number (out_number)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (started) begin
            n_cmp++;
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_valid cyc=%0d got=%0d want=no_output", cyc, out_number);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (out_number !== OW'(e.val) || cyc != e.cyc) begin
                        n_bad++;
                        $display("FAIL result got=%0d@cyc%0d want=%0d@cyc%0d", out_number, cyc, e.val, e.cyc);
                    end
                end
            end else if (out_number !== '0) begin
                n_bad++;
                $display("FAIL idle_zero cyc=%0d got=%0d want=0", cyc, out_number);
            end
        end
    end

    task automatic drive(input bit v, input logic [1:0] m, input bit clr,
                         input int a, input int b, input int c, input int d, input int e,
                         input int exp_val, input bit push, input bit rst);
        @(posedge clk);
        #1;
        rst_n     = rst;
        in_valid  = v;
        mode      = m;
        acc_clr   = clr;
        in_number = {5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
        if (push && v && !rst) q.push_back('{exp_val, cyc + 3});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1; in_valid = 0; mode = 0; in_number = '0; acc_clr = 0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_number !== '0) begin
            n_bad++;
            $display("FAIL reset_state got=%b/%0d want=0/0", out_valid, out_number);
        end
        started = 1;
        idle(2);
        // SUM of max operands, then an idle cycle that must read zero
        drive(1, 2'b00, 0, 31, 31, 31, 31, 31, 155, 1, 0);
        idle(2);
        // RANGE then MAC back-to-back
        drive(1, 2'b01, 0, 3, 17, 9, 0, 25, 25, 1, 0);
        drive(1, 2'b10, 0, 31, 31, 31, 5, 9, 992, 1, 0);
        drive(1, 2'b01, 0, 7, 7, 7, 7, 7, 0, 1, 0);
        // accumulator saturation
        drive(1, 2'b11, 1, 31, 31, 31, 31, 31, 155, 1, 0);
        drive(1, 2'b11, 0, 31, 31, 31, 31, 31, 310, 1, 0);
        drive(1, 2'b11, 0, 31, 31, 31, 31, 31, 465, 1, 0);
        drive(1, 2'b11, 0, 31, 31, 31, 31, 31, 620, 1, 0);
        drive(1, 2'b11, 0, 31, 31, 31, 31, 31, 775, 1, 0);
        drive(1, 2'b11, 0, 31, 31, 31, 31, 31, 930, 1, 0);
        drive(1, 2'b11, 0, 31, 31, 31, 31, 31, 1023, 1, 0);
        // build the accumulator to 500, then clear with an ACC
        drive(1, 2'b11, 1, 20, 20, 20, 20, 20, 100, 1, 0);
        for (int i = 2; i <= 5; i++) drive(1, 2'b11, 0, 20, 20, 20, 20, 20, 100 * i, 1, 0);
        drive(1, 2'b11, 1, 1, 1, 1, 1, 1, 5, 1, 0);
        // clear on a non-ACC transaction leaves its result intact
        drive(1, 2'b00, 1, 1, 2, 3, 4, 5, 15, 1, 0);
        drive(1, 2'b11, 0, 1, 1, 1, 1, 1, 5, 1, 0);
        // invalid cycle carrying ACC+clear must be ignored
        drive(0, 2'b11, 1, 31, 31, 31, 31, 31, 0, 0, 0);
        drive(1, 2'b11, 0, 1, 1, 1, 1, 1, 10, 1, 0);
        // idle gap pattern 1,0,1
        drive(1, 2'b00, 0, 1, 1, 1, 1, 1, 5, 1, 0);
        idle(1);
        drive(1, 2'b00, 0, 2, 2, 2, 2, 2, 10, 1, 0);
        idle(4);
        // reset flush: two in flight, one offered during reset
        drive(1, 2'b11, 0, 31, 31, 31, 31, 31, 0, 0, 0);
        drive(1, 2'b00, 0, 9, 9, 9, 9, 9, 0, 0, 0);
        drive(1, 2'b11, 0, 4, 4, 4, 4, 4, 0, 0, 1);
        drive(1, 2'b11, 0, 1, 1, 1, 1, 1, 5, 1, 0);
        idle(1);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout pending=%0d want=0", q.size());
        end
        idle(3);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
